// File: rtl/count_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : count_pkg
//  Purpose  : Shared encodings for the programmable counter family:
//             count direction and limit-handling mode.
//  Revision : 1.0  initial release
// ============================================================================
package count_pkg;

    // Count direction as seen on the dir input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Limit handling selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage : count_pkg
`default_nettype wire

// File: rtl/count_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : count_prescaler
//  Purpose  : Divides the enable stream by PRESCALE. tick is high on the
//             enabled cycle that completes a prescale period.
//  Revision : 1.0  initial release
// ============================================================================
module count_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A 1-bit counter is kept for PRESCALE=1; its terminal value is 0, so it
    // never leaves 0 and tick degenerates to en.
    localparam int                 c_psc_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_psc_w-1:0] c_psc_last = c_psc_w'(PRESCALE - 1);

    logic [c_psc_w-1:0] r_psc;

    // Prescale phase: cleared by reset or load, advanced only on enabled cycles
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_psc <= '0;
        end else if (en) begin
            if (r_psc == c_psc_last) begin
                r_psc <= '0;
            end else begin
                r_psc <= r_psc + c_psc_w'(1);
            end
        end
    end

    assign tick = en && (r_psc == c_psc_last);

endmodule : count_prescaler
`default_nettype wire

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
//  Module   : prog_counter
//  Purpose  : Up/down modulo counter with prescaler, parallel load, and
//             wrap or saturate behaviour at the limits. out and tc are
//             registered and aligned with each other.
//  Revision : 1.0  initial release
// ============================================================================
module prog_counter
    import count_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int MODULUS  = 32,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_max    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_max_m1 = WIDTH'(MODULUS - 2);
    localparam logic [WIDTH-1:0] c_one    = WIDTH'(1);
    localparam bit               c_sat    = (SATURATE == MODE_SAT);

    // Refuse to elaborate with a count range the output cannot represent
    generate
        if (!((MODULUS >= 2) && (longint'(MODULUS) <= (longint'(1) << WIDTH)) &&
              (PRESCALE >= 1) &&
              ((SATURATE == MODE_WRAP) || (SATURATE == MODE_SAT)))) begin : g_bad_params
            $fatal(1, "prog_counter: illegal WIDTH/MODULUS/SATURATE/PRESCALE combination");
        end
    endgenerate

    logic             w_tick;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_tc;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;

    // Load restarts the prescale period so the first step after a load
    // always takes a full PRESCALE enabled cycles.
    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (w_tick)
    );

    // Next count and terminal flag for a step in the current direction
    always_comb begin
        w_step_val = r_out;
        w_step_tc  = 1'b0;
        case (dir)
            DIR_UP: begin
                if (r_out == c_max) begin
                    if (!c_sat) begin
                        w_step_val = '0;
                        w_step_tc  = 1'b1;
                    end
                end else begin
                    w_step_val = r_out + c_one;
                    w_step_tc  = c_sat && (r_out == c_max_m1);
                end
            end
            DIR_DOWN: begin
                if (r_out == '0) begin
                    if (!c_sat) begin
                        w_step_val = c_max;
                        w_step_tc  = 1'b1;
                    end
                end else begin
                    w_step_val = r_out - c_one;
                    w_step_tc  = c_sat && (r_out == c_one);
                end
            end
        endcase
    end

    // Count register: reset beats load, load beats a step; tc is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_tc  <= 1'b0;
        end else if (load) begin
            r_out <= (load_val > c_max) ? c_max : load_val;
            r_tc  <= 1'b0;
        end else if (w_tick) begin
            r_out <= w_step_val;
            r_tc  <= w_step_tc;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign out = r_out;
    assign tc  = r_tc;

endmodule : prog_counter
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_counter
//  Purpose  : Self-checking bench for prog_counter. Four instances cover the
//             default wrap counter, a saturating modulo-10 counter, a
//             prescaled counter and a 6-bit modulo-40 counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_counter;

    typedef struct {
        int    unit;
        int    out;
        bit    tc;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [3:0] en;
    logic [3:0] dir;
    logic [3:0] load;
    logic [5:0] lv [4];
    logic [4:0] out0, out1, out2;
    logic [5:0] out3;
    logic [3:0] tc;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    prog_counter u_dut0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .dir(dir[0]), .load(load[0]),
        .load_val(lv[0][4:0]), .out(out0), .tc(tc[0])
    );

    prog_counter #(.MODULUS(10), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .dir(dir[1]), .load(load[1]),
        .load_val(lv[1][4:0]), .out(out1), .tc(tc[1])
    );

    prog_counter #(.PRESCALE(4)) u_dut2 (
        .clk(clk), .rst(rst[2]), .en(en[2]), .dir(dir[2]), .load(load[2]),
        .load_val(lv[2][4:0]), .out(out2), .tc(tc[2])
    );

    prog_counter #(.WIDTH(6), .MODULUS(40)) u_dut3 (
        .clk(clk), .rst(rst[3]), .en(en[3]), .dir(dir[3]), .load(load[3]),
        .load_val(lv[3]), .out(out3), .tc(tc[3])
    );

    function automatic logic [5:0] get_out(int u);
        case (u)
            0:       return {1'b0, out0};
            1:       return {1'b0, out1};
            2:       return {1'b0, out2};
            default: return out3;
        endcase
    endfunction

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then compare every expectation queued for this edge
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({e.tag, ".out"}, 32'(get_out(e.unit)), e.out);
            check_eq({e.tag, ".tc"},  32'(tc[e.unit]),      32'(e.tc));
        end
    endtask

    // Drive one cycle on one instance, queue its expected result, then idle it
    task automatic drive(int u, bit r, bit e, bit d, bit l, int v,
                         int eo, bit et, string tag);
        rst[u]  = r;
        en[u]   = e;
        dir[u]  = d;
        load[u] = l;
        lv[u]   = 6'(v);
        sb.push_back('{unit: u, out: eo, tc: et, tag: tag});
        step();
        rst[u]  = 1'b0;
        en[u]   = 1'b0;
        load[u] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst  = '1;
        en   = '0;
        dir  = '0;
        load = '0;
        for (int u = 0; u < 4; u++) lv[u] = '0;
        #1;

        // Reset state of all instances
        for (int u = 0; u < 4; u++) sb.push_back('{unit: u, out: 0, tc: 1'b0, tag: $sformatf("rst%0d", u)});
        step();
        rst = '0;

        // Default counter: count up through the wrap
        for (int i = 1; i <= 34; i++)
            drive(0, 0, 1, 1, 0, 0, i % 32, (i == 32), $sformatf("up%0d", i));

        // Reset wins over load; then a down step wraps to the top
        drive(0, 0, 0, 0, 1, 17, 17, 0, "ld17");
        drive(0, 1, 0, 0, 1, 5,  0,  0, "rst_ld");
        drive(0, 0, 1, 0, 0, 0,  31, 1, "dn_wrap");
        drive(0, 0, 1, 0, 0, 0,  30, 0, "dn30");

        // Saturating modulo-10: hold at both limits, tc only on arrival
        drive(1, 0, 0, 0, 1, 3,  3, 0, "s_ld3");
        drive(1, 0, 1, 0, 0, 0,  2, 0, "s_dn2");
        drive(1, 0, 1, 0, 0, 0,  1, 0, "s_dn1");
        drive(1, 0, 1, 0, 0, 0,  0, 1, "s_dn0");
        drive(1, 0, 1, 0, 0, 0,  0, 0, "s_hold0");
        drive(1, 0, 1, 1, 0, 0,  1, 0, "s_leave0");
        drive(1, 0, 0, 0, 1, 8,  8, 0, "s_ld8");
        drive(1, 0, 1, 1, 0, 0,  9, 1, "s_up9");
        drive(1, 0, 1, 1, 0, 0,  9, 0, "s_hold9");
        drive(1, 0, 1, 0, 0, 0,  8, 0, "s_leave9");
        drive(1, 0, 0, 0, 1, 15, 9, 0, "s_clamp15");
        drive(1, 0, 1, 1, 0, 0,  9, 0, "s_hold_after_ld");

        // Prescale by 4: steps every fourth enabled cycle
        for (int i = 1; i <= 12; i++)
            drive(2, 0, 1, 1, 0, 0, i / 4, 0, $sformatf("p_en%0d", i));
        for (int i = 1; i <= 3; i++)
            drive(2, 0, 0, 1, 0, 0, 3, 0, $sformatf("p_idle%0d", i));
        for (int i = 1; i <= 4; i++)
            drive(2, 0, 1, 1, 0, 0, (i == 4) ? 4 : 3, 0, $sformatf("p_resume%0d", i));
        // Direction change mid-period keeps the phase
        drive(2, 0, 1, 1, 0, 0, 4, 0, "p_dir1");
        drive(2, 0, 1, 1, 0, 0, 4, 0, "p_dir2");
        drive(2, 0, 1, 0, 0, 0, 4, 0, "p_dir3");
        drive(2, 0, 1, 0, 0, 0, 3, 0, "p_dir4");
        // Load mid-period restarts the phase and suppresses the step
        drive(2, 0, 1, 0, 0, 0, 3, 0, "p_pre1");
        drive(2, 0, 1, 0, 0, 0, 3, 0, "p_pre2");
        drive(2, 0, 1, 0, 1, 10, 10, 0, "p_ld10");
        for (int i = 1; i <= 4; i++)
            drive(2, 0, 1, 0, 0, 0, (i == 4) ? 9 : 10, 0, $sformatf("p_afterld%0d", i));
        // Reset mid-period: full period before the next step
        drive(2, 0, 1, 1, 0, 0, 9, 0, "p_pr1");
        drive(2, 0, 1, 1, 0, 0, 9, 0, "p_pr2");
        drive(2, 1, 1, 1, 0, 0, 0, 0, "p_rst");
        for (int i = 1; i <= 4; i++)
            drive(2, 0, 1, 1, 0, 0, (i == 4) ? 1 : 0, 0, $sformatf("p_afterrst%0d", i));

        // 6-bit modulo-40: clamp on load, no step with load, wrap both ways
        drive(3, 0, 1, 1, 1, 50, 39, 0, "m_ld50");
        drive(3, 0, 1, 1, 0, 0,  0,  1, "m_upwrap");
        drive(3, 0, 1, 1, 0, 0,  1,  0, "m_up1");
        drive(3, 0, 0, 1, 1, 40, 39, 0, "m_ld40");
        drive(3, 0, 0, 1, 1, 0,  0,  0, "m_ld0");
        drive(3, 0, 1, 0, 0, 0,  39, 1, "m_dnwrap");
        drive(3, 0, 1, 0, 0, 0,  38, 0, "m_dn38");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prog_counter
`default_nettype wire

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5: counter width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 32: count range 0..MODULUS-1.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-004 The block SHALL have parameter PRESCALE, default 1: enabled cycles per count step.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: count enable; advances the prescaler.
REQ-008 The block SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: value to load.
REQ-011 The block SHALL have port out, output, WIDTH bits: registered count value.
REQ-012 The block SHALL have port tc, output, 1 bit: registered terminal-count pulse.

Function
REQ-013 Elaboration SHALL fail unless 2 <= MODULUS <= 2**WIDTH and PRESCALE >= 1.
REQ-014 The prescaler SHALL be an internal counter psc over 0..PRESCALE-1.
  - en=1: psc increments.
  - en=0: psc holds.
  - tick = en && psc==PRESCALE-1; on tick, psc returns to 0.
REQ-015 With PRESCALE=1, tick SHALL equal en.
REQ-016 On tick with dir=1, out SHALL increment.
  - At out==MODULUS-1: out becomes 0 (SATURATE=0) or holds (SATURATE=1).
REQ-017 On tick with dir=0, out SHALL decrement.
  - At out==0: out becomes MODULUS-1 (SATURATE=0) or holds (SATURATE=1).
REQ-018 Priority SHALL be rst > load > tick.
REQ-019 On load, out SHALL take load_val, clamped to MODULUS-1 when load_val >= MODULUS.
  - psc clears to 0.
  - tc is 0 in the following cycle.
  - No step occurs that cycle, even if en=1.
REQ-020 In SATURATE=0, tc SHALL be 1 for exactly the one cycle in which out shows a wrapped value (0 after up-wrap, MODULUS-1 after down-wrap); otherwise tc is 0.
REQ-021 In SATURATE=1, tc SHALL be 1 for the one cycle in which out first reaches the limit in the counting direction.
  - Further ticks held at the limit do not re-assert tc.
  - A tick in the opposite direction leaves the limit normally.
REQ-022 A change of dir SHALL not clear psc; the step direction is sampled on the tick cycle.
REQ-023 out SHALL update one clock after the tick or load cycle (latency 1); tc SHALL be aligned with out.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL set out=0, psc=0 and tc=0, regardless of en, load and dir.
REQ-025 Counting SHALL resume from 0, with a full prescale period, on the first cycle after rst is released.

Structure
REQ-026 A shared package count_pkg SHALL define:
  - DIR_UP=1 and DIR_DOWN=0.
  - MODE_WRAP=0 and MODE_SAT=1.
REQ-027 The prescaler SHALL be a sub-module count_prescaler with:
  - parameter PRESCALE;
  - ports clk, rst, en, clr, tick.
REQ-028 prog_counter SHALL instantiate count_prescaler once; the limit, step and tc logic stays in prog_counter.

Verification
REQ-029 Defaults; rst high 1 cycle, then en=1, dir=1 for 34 cycles -> out 1..31, then 0; tc=1 only in the cycle out=0 after the wrap.
REQ-030 MODULUS=10, SATURATE=1; load_val=3, then en=1, dir=0 for 5 cycles -> out 3,2,1,0,0; tc=1 only in the first cycle out=0.
REQ-031 PRESCALE=4, en=1 for 12 cycles -> out steps to 1, 2, 3 after enabled cycles 4, 8, 12. Then:
  - en=0 for 3 cycles -> out and psc hold.
  - en=1 for 4 cycles -> one more step.
REQ-032 WIDTH=6, MODULUS=40; load=1, load_val=50 and en=1 in the same cycle -> out=39 next cycle, tc=0, no step.
REQ-033 Mid-count, out=17, with rst=1 and load=1 together -> out=0, tc=0 next cycle. Then en=1, dir=0, SATURATE=0 -> out=MODULUS-1, with tc=1 in that cycle.
